// File: rtl/fracture_pkg.sv
// Shared definitions for the fracture detector: state encoding and datapath widths.
package fracture_pkg;

  localparam int SAMPLE_W = 16;
  localparam int HIT_W    = 8;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_ALARM = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/fracture_peak.sv
// Running-maximum register for ring-phase samples; clear has priority over update.
module fracture_peak
  import fracture_pkg::*;
(
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                upd,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] peak
);

  logic [SAMPLE_W-1:0] peak_reg;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      peak_reg <= '0;
    end else if (clr) begin
      peak_reg <= '0;
    end else if (upd && (sample > peak_reg)) begin
      peak_reg <= sample;
    end
  end

  assign peak = peak_reg;

endmodule

// File: rtl/fracture_ctrl.sv
// Fracture alarm controller: counts consecutive threshold hits, raises an alarm,
// and holds off re-arming for a programmable number of samples after a clear.
module fracture_ctrl
  import fracture_pkg::*;
(
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] ph_ring,
  input  logic                ph_vld,
  input  logic                cfg_en,
  input  logic [SAMPLE_W-1:0] cfg_ring_th,
  input  logic [HIT_W-1:0]    cfg_hit_num,
  input  logic [15:0]         cfg_hold,
  input  logic                clr_action,
  output logic                stu_action,
  output logic                irq_action,
  output logic [1:0]          stu_state,
  output logic [HIT_W-1:0]    stu_hit_cnt,
  output logic [SAMPLE_W-1:0] stu_peak,
  output logic [CNT_W-1:0]    stu_act_cnt
);

  state_e           state_reg;
  logic [HIT_W-1:0] hit_cnt_reg;
  logic [15:0]      hold_cnt_reg;
  logic [CNT_W-1:0] act_cnt_reg;
  logic             action_reg;
  logic             irq_reg;

  logic             is_hit;
  logic [HIT_W-1:0] hit_inc;
  logic [HIT_W-1:0] hit_need;
  logic             hold_done;
  logic             peak_clr;
  logic             peak_upd;

  assign is_hit    = (ph_ring >= cfg_ring_th);
  assign hit_inc   = (hit_cnt_reg == {HIT_W{1'b1}}) ? hit_cnt_reg : hit_cnt_reg + 1'b1;
  assign hit_need  = (cfg_hit_num == '0) ? HIT_W'(1) : cfg_hit_num;
  assign hold_done = (hold_cnt_reg == cfg_hold);

  // Peak is zeroed throughout IDLE and on the HOLD->ARM re-arm; a clear in ALARM blocks the update.
  assign peak_clr = !cfg_en || (state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && hold_done);
  assign peak_upd = cfg_en && ph_vld &&
                    ((state_reg == ST_ARM) || ((state_reg == ST_ALARM) && !clr_action));

  fracture_peak u_peak (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (peak_clr),
    .upd     (peak_upd),
    .sample  (ph_ring),
    .peak    (stu_peak)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      hit_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      act_cnt_reg  <= '0;
      action_reg   <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      irq_reg <= 1'b0;
      if (!cfg_en) begin
        state_reg   <= ST_IDLE;
        hit_cnt_reg <= '0;
        action_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            state_reg   <= ST_ARM;
            hit_cnt_reg <= '0;
          end
          ST_ARM: begin
            if (ph_vld) begin
              if (is_hit) begin
                hit_cnt_reg <= hit_inc;
                if (hit_inc >= hit_need) begin
                  state_reg  <= ST_ALARM;
                  action_reg <= 1'b1;
                  irq_reg    <= 1'b1;
                  if (act_cnt_reg != {CNT_W{1'b1}}) begin
                    act_cnt_reg <= act_cnt_reg + 1'b1;
                  end
                end
              end else begin
                hit_cnt_reg <= '0;
              end
            end
          end
          ST_ALARM: begin
            if (clr_action) begin
              state_reg    <= ST_HOLD;
              action_reg   <= 1'b0;
              hold_cnt_reg <= '0;
            end
          end
          ST_HOLD: begin
            if (hold_done) begin
              state_reg   <= ST_ARM;
              hit_cnt_reg <= '0;
            end else if (ph_vld) begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign stu_action  = action_reg;
  assign irq_action  = irq_reg;
  assign stu_state   = state_reg;
  assign stu_hit_cnt = hit_cnt_reg;
  assign stu_act_cnt = act_cnt_reg;

endmodule

// File: tb/tb_fracture_ctrl.sv
// Randomised and directed bench for fracture_ctrl against a behavioural alarm model.
module tb_fracture_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [15:0] ph_ring;
  logic        ph_vld;
  logic        cfg_en;
  logic [15:0] cfg_ring_th;
  logic [7:0]  cfg_hit_num;
  logic [15:0] cfg_hold;
  logic        clr_action;
  logic        stu_action;
  logic        irq_action;
  logic [1:0]  stu_state;
  logic [7:0]  stu_hit_cnt;
  logic [15:0] stu_peak;
  logic [15:0] stu_act_cnt;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // Model of the alarm behaviour: mode 0 idle, 1 armed, 2 alarmed, 3 holding off.
  int m_mode   = 0;
  int m_streak = 0;
  int m_peak   = 0;
  int m_alarms = 0;
  int m_seen   = 0;
  bit m_alarm  = 1'b0;
  bit m_irq    = 1'b0;

  always #5 clk_sys = ~clk_sys;

  fracture_ctrl dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .ph_ring     (ph_ring),
    .ph_vld      (ph_vld),
    .cfg_en      (cfg_en),
    .cfg_ring_th (cfg_ring_th),
    .cfg_hit_num (cfg_hit_num),
    .cfg_hold    (cfg_hold),
    .clr_action  (clr_action),
    .stu_action  (stu_action),
    .irq_action  (irq_action),
    .stu_state   (stu_state),
    .stu_hit_cnt (stu_hit_cnt),
    .stu_peak    (stu_peak),
    .stu_act_cnt (stu_act_cnt)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk_sys or negedge rst_n) begin
    int need;
    int streak;
    if (!rst_n) begin
      m_mode <= 0; m_streak <= 0; m_peak <= 0; m_alarms <= 0;
      m_seen <= 0; m_alarm <= 1'b0; m_irq <= 1'b0;
    end else begin
      need = (cfg_hit_num == 0) ? 1 : int'(cfg_hit_num);
      m_irq <= 1'b0;
      if (!cfg_en) begin
        m_mode <= 0; m_streak <= 0; m_peak <= 0; m_alarm <= 1'b0;
      end else if (m_mode == 0) begin
        m_mode <= 1; m_streak <= 0; m_peak <= 0;
      end else if (m_mode == 1) begin
        if (ph_vld) begin
          streak = (ph_ring >= cfg_ring_th) ? ((m_streak >= 255) ? 255 : m_streak + 1) : 0;
          m_streak <= streak;
          if (int'(ph_ring) > m_peak) m_peak <= int'(ph_ring);
          if (streak >= need) begin
            m_mode <= 2; m_alarm <= 1'b1; m_irq <= 1'b1;
            m_alarms <= (m_alarms >= 65535) ? 65535 : m_alarms + 1;
          end
        end
      end else if (m_mode == 2) begin
        if (clr_action) begin
          m_mode <= 3; m_alarm <= 1'b0; m_seen <= 0;
        end else if (ph_vld && int'(ph_ring) > m_peak) begin
          m_peak <= int'(ph_ring);
        end
      end else begin
        if (m_seen == int'(cfg_hold)) begin
          m_mode <= 1; m_streak <= 0; m_peak <= 0;
        end else if (ph_vld) begin
          m_seen <= (m_seen + 1) % 65536;
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    if (check_en) begin
      check("model_state",   32'(stu_state),   32'(m_mode));
      check("model_action",  32'(stu_action),  32'(m_alarm));
      check("model_irq",     32'(irq_action),  32'(m_irq));
      check("model_hit_cnt", 32'(stu_hit_cnt), 32'(m_streak));
      check("model_peak",    32'(stu_peak),    32'(m_peak));
      check("model_act_cnt", 32'(stu_act_cnt), 32'(m_alarms));
    end
  end

  task automatic drive(input logic v, input logic [15:0] r, input logic c);
    @(negedge clk_sys);
    ph_vld = v; ph_ring = r; clr_action = c;
  endtask

  initial begin
    rst_n = 1'b0; ph_ring = '0; ph_vld = 1'b0; clr_action = 1'b0;
    cfg_en = 1'b1; cfg_ring_th = 16'h1000; cfg_hit_num = 8'd3; cfg_hold = 16'd2;
    repeat (3) @(negedge clk_sys);
    check_en = 1'b1;
    check("reset_state",   32'(stu_state),   32'd0);
    check("reset_act_cnt", 32'(stu_act_cnt), 32'd0);
    check("reset_peak",    32'(stu_peak),    32'd0);
    rst_n = 1'b1;
    drive(0, 16'h0, 0);
    check("arm_after_release", 32'(stu_state), 32'd1);

    // Three consecutive hits raise the alarm one cycle after the third sample.
    drive(1, 16'h1000, 0);
    drive(1, 16'h1200, 0);
    drive(1, 16'h1001, 0);
    drive(0, 16'h0, 0);
    check("alarm_action", 32'(stu_action),  32'd1);
    check("alarm_irq",    32'(irq_action),  32'd1);
    check("alarm_cnt",    32'(stu_act_cnt), 32'd1);
    check("alarm_peak",   32'(stu_peak),    32'h1200);
    drive(0, 16'h0, 0);
    check("irq_one_cycle", 32'(irq_action), 32'd0);

    // Clear with a simultaneous max sample: clear wins, peak untouched.
    drive(1, 16'hFFFF, 1);
    drive(0, 16'h0, 0);
    check("clr_state",  32'(stu_state),  32'd3);
    check("clr_action", 32'(stu_action), 32'd0);
    check("clr_peak",   32'(stu_peak),   32'h1200);
    drive(1, 16'h0005, 0);
    drive(1, 16'h0005, 0);
    drive(0, 16'h0, 0);
    check("hold2_still_hold", 32'(stu_state), 32'd3);
    drive(0, 16'h0, 0);
    check("hold2_rearm",      32'(stu_state), 32'd1);
    check("rearm_peak",       32'(stu_peak),  32'd0);

    // Broken streak: hit, hit, miss, hit, hit leaves count 2 and no alarm.
    drive(1, 16'h2000, 0);
    drive(1, 16'h2000, 0);
    drive(1, 16'h0FFF, 0);
    drive(1, 16'h2000, 0);
    drive(1, 16'h2000, 0);
    drive(0, 16'h0, 0);
    check("streak_hit_cnt", 32'(stu_hit_cnt), 32'd2);
    check("streak_no_alarm", 32'(stu_action), 32'd0);
    drive(1, 16'h3000, 0);
    drive(0, 16'h0, 0);
    check("streak_alarm_cnt", 32'(stu_act_cnt), 32'd2);
    check("streak_peak",      32'(stu_peak),    32'h3000);

    cfg_hold = 16'd0;
    drive(0, 16'h0, 1);
    drive(0, 16'h0, 0);
    check("hold0_enter", 32'(stu_state), 32'd3);
    drive(0, 16'h0, 0);
    check("hold0_rearm", 32'(stu_state), 32'd1);

    // hit_num of zero behaves as one; disabling from ALARM clears all but the alarm count.
    cfg_hit_num = 8'd0;
    drive(1, 16'h1000, 0);
    drive(0, 16'h0, 0);
    check("hitnum0_alarm", 32'(stu_action),  32'd1);
    check("hitnum0_cnt",   32'(stu_act_cnt), 32'd3);
    cfg_en = 1'b0;
    drive(0, 16'h0, 0);
    check("dis_state",   32'(stu_state),   32'd0);
    check("dis_action",  32'(stu_action),  32'd0);
    check("dis_hit_cnt", 32'(stu_hit_cnt), 32'd0);
    check("dis_peak",    32'(stu_peak),    32'd0);
    check("dis_act_cnt", 32'(stu_act_cnt), 32'd3);
    cfg_en = 1'b1;
    drive(0, 16'h0, 0);
    check("reen_state", 32'(stu_state), 32'd1);

    // Asynchronous reset while holding off.
    cfg_hit_num = 8'd1;
    cfg_hold = 16'd5;
    drive(1, 16'h1000, 0);
    drive(0, 16'h0, 1);
    drive(0, 16'h0, 0);
    check("pre_rst_state", 32'(stu_state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state",   32'(stu_state),   32'd0);
    check("async_rst_act_cnt", 32'(stu_act_cnt), 32'd0);
    check("async_rst_hit_cnt", 32'(stu_hit_cnt), 32'd0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    drive(0, 16'h0, 0);
    check("post_rst_irq",   32'(irq_action), 32'd0);
    check("post_rst_state", 32'(stu_state),  32'd1);

    // Randomised traffic checked cycle by cycle against the model.
    cfg_ring_th = 16'h8000;
    cfg_hit_num = 8'd2;
    cfg_hold    = 16'd1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_sys);
      rst_n      = 1'b1;
      ph_vld     = ($urandom_range(0, 3) != 0);
      ph_ring    = 16'($urandom);
      clr_action = ($urandom_range(0, 7) == 0);
      cfg_en     = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 99) == 0) cfg_hit_num = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) cfg_hold    = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) cfg_ring_th = 16'($urandom_range(16'h4000, 16'hC000));
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
      end
    end
    @(negedge clk_sys);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
